// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   lsu_op_e     operation encoding presented on the request port
//   lsu_state_e  FSM state encoding (also visible on the debug state port)
//   is_load / is_subword / is_misaligned  op classification helpers
// Configuration macro: LSU_MISALIGN_TRAP_EN adds the S_ERR state.
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
`ifdef LSU_MISALIGN_TRAP_EN
    , S_ERR = 3'd5
`endif
  } lsu_state_e;

  function automatic logic is_load(input lsu_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  // Sub-word stores need the old word first (read-modify-write).
  function automatic logic is_subword(input lsu_op_e op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

  // Word ops need addr[1:0]==0, halfword ops need addr[0]==0; bytes never trap.
  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW:          bad = (off != 2'b00);
      OP_LH, OP_LHU, OP_SH:  bad = off[0];
      default:               bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// -----------------------------------------------------------------------------
// lsu_byte_lane
// Combinational lane steering for the load/store unit (little-endian lanes).
//   word_i    32-bit word read from memory
//   off_i     byte offset addr[1:0]
//   op_i      operation
//   store_i   store operand (SB uses [7:0], SH uses [15:0])
//   load_o    sign/zero-extended load result
//   merged_o  write word: store_i for SW, word_i with addressed lanes replaced
//             for SH/SB
// -----------------------------------------------------------------------------
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  lsu_op_e     op_i,
  input  logic [31:0] store_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    load_o = word_i;
    case (op_i)
      OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_o = {16'h0000, half_sel};
      OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_o = {24'h000000, byte_sel};
      default: load_o = word_i;
    endcase

    merged_o = word_i;
    case (op_i)
      OP_SW: merged_o = store_i;
      OP_SH: begin
        if (off_i[1]) merged_o[31:16] = store_i[15:0];
        else          merged_o[15:0]  = store_i[15:0];
      end
      OP_SB:   merged_o[{off_i, 3'b000} +: 8] = store_i[7:0];
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-side stage between the multicycle datapath and DataMemory. Accepts
// one load/store at a time, issues word-aligned accesses, does
// read-modify-write for SH/SB, and holds the extended load result.
//
// Ports:
//   clock, reset_n        clock; synchronous active-low reset
//   start, op, addr,      request (accepted only while ready=1)
//   store_data
//   ready, done, err      ready in IDLE; one-cycle done; err valid with done
//   load_data             extended load result, held until the next load
//   mem_*                 DataMemory interface (read data valid the cycle
//                         after mem_read is first asserted)
//   dbg_state             current FSM state (lsu_state_e encoding)
//
// Handshake: a request is taken on a rising edge where start=1 and ready=1;
// op/addr/store_data are don't-care afterwards. Exactly one done pulse
// follows each accepted request, and ready returns the cycle after done.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN -- misaligned word/halfword
// requests complete with err=1 and no memory access. Undefined: err is 0
// and the low address bits not relevant to the access size are ignored.
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  ready,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           load_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [31:0]           mem_read_data,
  output logic [2:0]            dbg_state
);

  lsu_state_e            state_q, state_d;
  lsu_op_e               op_q;
  lsu_op_e               op_in;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           sdata_q;
  logic [31:0]           word_q;
  logic [31:0]           load_data_q;
  logic                  accept;
  logic [31:0]           lane_word;
  logic [31:0]           lane_load;
  logic [31:0]           lane_merged;

  assign op_in  = lsu_op_e'(op);
  assign accept = (state_q == S_IDLE) && start;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic err_q;
  assign misaligned = is_misaligned(op_in, addr[1:0]);
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_in == OP_SW) state_d = S_WRITE;
          else                state_d = S_READ;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) state_d = S_ERR;
`endif
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = is_load(op_q) ? S_DONE : S_WRITE;
      S_WRITE: state_d = S_DONE;
`ifdef LSU_MISALIGN_TRAP_EN
      S_ERR:   state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LW;
      addr_q      <= '0;
      sdata_q     <= '0;
      word_q      <= '0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op_in;
        addr_q  <= addr;
        sdata_q <= store_data;
      end
      // Read data is live during WAIT: extend it straight into load_data and
      // keep the raw word for the merge in WRITE.
      if (state_q == S_WAIT) begin
        word_q <= mem_read_data;
        if (is_load(op_q)) load_data_q <= lane_load;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned;
    end
  end
  assign err = (state_q == S_DONE) && err_q;
`else
  assign err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Lane steering
  // ---------------------------------------------------------------------------
  assign lane_word = (state_q == S_WAIT) ? mem_read_data : word_q;

  lsu_byte_lane u_lane (
    .word_i   (lane_word),
    .off_i    (addr_q[1:0]),
    .op_i     (op_q),
    .store_i  (sdata_q),
    .load_o   (lane_load),
    .merged_o (lane_merged)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign load_data = load_data_q;
  assign mem_read  = (state_q == S_READ) || (state_q == S_WAIT);
  assign mem_write = (state_q == S_WRITE);
  assign dbg_state = state_q;

  // Address and write data are only driven during an access; otherwise 0.
  assign mem_address    = (mem_read || mem_write) ?
                          {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_write_data = mem_write ? lane_merged : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a small behavioural DataMemory.
// Covers reset values, all load extensions, SW/SH/SB, the misalignment path
// for whichever LSU_MISALIGN_TRAP_EN setting is compiled, reset during WAIT,
// and start held high while busy.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        ready, done, err;
  logic [31:0] load_data, mem_address, mem_write_data;
  logic        mem_read, mem_write;
  logic [31:0] mem_read_data = 32'h0;
  logic [2:0]  dbg_state;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 clock = ~clock;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .op             (op),
    .addr           (addr),
    .store_data     (store_data),
    .ready          (ready),
    .done           (done),
    .err            (err),
    .load_data      (load_data),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .dbg_state      (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // DataMemory model (16 words) with bench-side poke port
  // ---------------------------------------------------------------------------
  logic [31:0] mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = 4'd0;
  logic [31:0] poke_val = 32'h0;

  always @(posedge clock) begin
    if (poke_en)        mem[poke_idx] = poke_val;
    else if (mem_write) mem[mem_address[5:2]] = mem_write_data;
    if (mem_read) mem_read_data <= mem[mem_address[5:2]];
  end

  // Bus monitor
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  logic [31:0] last_wa = 32'h0, last_wd = 32'h0;

  always @(posedge clock) begin
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_wa = mem_address;
      last_wd = mem_write_data;
    end
    if (done) done_cnt++;
    if (mem_read && mem_write) overlap_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  int req_lat, req_rd, req_wr, req_err;

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clock);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Issues one request and returns latency (cycles from the accepting edge to
  // the cycle where done is high) and bus activity counts.
  task automatic do_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    int rd0, wr0;
    bit seen;
    @(negedge clock);
    start = 1'b1; op = o; addr = a; store_data = d;
    rd0 = rd_cnt; wr0 = wr_cnt; seen = 1'b0; req_lat = 0; req_err = 0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clock);
      start = 1'b0;
      req_lat++;
      if (done) begin
        seen = 1'b1;
        req_err = int'(err);
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    req_rd = rd_cnt - rd0;
    req_wr = wr_cnt - wr0;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] exp);
    exp_q.push_back(exp);
    do_req(o, a, 32'h0);
    check_eq({tag, "_lat"}, req_lat, 32'd3);
    check_eq({tag, "_rd"}, req_rd, 32'd2);
    check_eq({tag, "_err"}, req_err, 32'd0);
    check_eq({tag, "_data"}, load_data, exp_q.pop_front());
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int d0, rd0, wr0;

    reset_n = 1'b0;
    poke(4'd11, 32'h8899AABB);         // word 0x2C
    @(negedge clock);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_load_data", load_data, 32'h0);
    check_eq("rst_mem_address", mem_address, 32'h0);
    check_eq("rst_mem_wdata", mem_write_data, 32'h0);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    reset_n = 1'b1;

    // Loads from 0x8899AABB
    load_chk("lw_2c",  OP_LW,  32'h2C, 32'h8899AABB);
    load_chk("lb_2f",  OP_LB,  32'h2F, 32'hFFFFFF88);
    load_chk("lbu_2f", OP_LBU, 32'h2F, 32'h00000088);
    load_chk("lhu_2c", OP_LHU, 32'h2C, 32'h0000AABB);
    load_chk("lh_2e",  OP_LH,  32'h2E, 32'hFFFF8899);
    load_chk("lb_2c",  OP_LB,  32'h2C, 32'hFFFFFFBB);
    load_chk("lbu_2d", OP_LBU, 32'h2D, 32'h000000AA);

    // SB read-modify-write
    do_req(OP_SB, 32'h2D, 32'hFFFFFF11);
    check_eq("sb_lat", req_lat, 32'd4);
    check_eq("sb_rd", req_rd, 32'd2);
    check_eq("sb_wr", req_wr, 32'd1);
    check_eq("sb_waddr", last_wa, 32'h2C);
    check_eq("sb_wdata", last_wd, 32'h889911BB);
    check_eq("sb_keeps_load", load_data, 32'h000000AA);
    load_chk("lw_after_sb", OP_LW, 32'h2C, 32'h889911BB);

    // SW then SH upper half
    do_req(OP_SW, 32'h30, 32'hCAFEF00D);
    check_eq("sw_lat", req_lat, 32'd2);
    check_eq("sw_rd", req_rd, 32'd0);
    check_eq("sw_wr", req_wr, 32'd1);
    check_eq("sw_wdata", last_wd, 32'hCAFEF00D);
    check_eq("sw_keeps_load", load_data, 32'h889911BB);
    do_req(OP_SH, 32'h32, 32'hDEAD1234);
    check_eq("sh_lat", req_lat, 32'd4);
    check_eq("sh_wdata", last_wd, 32'h1234F00D);
    load_chk("lw_after_sh", OP_LW, 32'h30, 32'h1234F00D);

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(OP_LW, 32'h2D, 32'h0);
    check_eq("mis_lw_lat", req_lat, 32'd2);
    check_eq("mis_lw_err", req_err, 32'd1);
    check_eq("mis_lw_rd", req_rd, 32'd0);
    check_eq("mis_lw_wr", req_wr, 32'd0);
    check_eq("mis_lw_keeps_load", load_data, 32'h1234F00D);
    do_req(OP_SH, 32'h31, 32'h0000BEEF);
    check_eq("mis_sh_err", req_err, 32'd1);
    check_eq("mis_sh_wr", req_wr, 32'd0);
    check_eq("mis_sh_mem", mem[12], 32'h1234F00D);
`else
    load_chk("mis_lw_2d", OP_LW, 32'h2D, 32'h889911BB);
    do_req(OP_SH, 32'h31, 32'h0000BEEF);
    check_eq("mis_sh_err", req_err, 32'd0);
    check_eq("mis_sh_mem", mem[12], 32'h1234BEEF);
`endif

    // start held high while an SW is in flight
    @(negedge clock);
    start = 1'b1; op = OP_SW; addr = 32'h34; store_data = 32'h00000055;
    d0 = done_cnt; rd0 = rd_cnt;
    @(negedge clock);                  // WRITE
    op = OP_LW; addr = 32'h2C;
    check_eq("busy_ready", 32'(ready), 32'd0);
    @(negedge clock);                  // DONE
    check_eq("busy_done", 32'(done), 32'd1);
    start = 1'b0;
    @(negedge clock);                  // IDLE
    check_eq("busy_ready_back", 32'(ready), 32'd1);
    check_eq("busy_done_cnt", done_cnt - d0, 32'd1);
    check_eq("busy_no_read", rd_cnt - rd0, 32'd0);
    check_eq("busy_mem", mem[13], 32'h00000055);
    load_chk("lw_after_busy", OP_LW, 32'h34, 32'h00000055);

    // Reset during WAIT of an SH
    poke(4'd11, 32'h8899AABB);
    @(negedge clock);
    start = 1'b1; op = OP_SH; addr = 32'h2E; store_data = 32'h00001234;
    wr0 = wr_cnt; d0 = done_cnt;
    @(negedge clock);                  // READ
    start = 1'b0;
    @(negedge clock);                  // WAIT
    check_eq("rw_in_wait", 32'(dbg_state), 32'(S_WAIT));
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_eq("rw_ready", 32'(ready), 32'd1);
    check_eq("rw_done", 32'(done), 32'd0);
    check_eq("rw_err", 32'(err), 32'd0);
    check_eq("rw_load_data", load_data, 32'h0);
    check_eq("rw_mem_address", mem_address, 32'h0);
    check_eq("rw_mem_wdata", mem_write_data, 32'h0);
    check_eq("rw_mem_read", 32'(mem_read), 32'd0);
    check_eq("rw_mem_write", 32'(mem_write), 32'd0);
    @(negedge clock);
    check_eq("rw_no_write", wr_cnt - wr0, 32'd0);
    check_eq("rw_no_done", done_cnt - d0, 32'd0);
    check_eq("rw_mem_intact", mem[11], 32'h8899AABB);
    load_chk("lhu_after_rst", OP_LHU, 32'h2E, 32'h00008899);

    check_eq("rd_wr_overlap", overlap_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side stage between the multicycle control/datapath and `DataMemory`. Accepts one load or store request at a time and generates word-aligned `DataMemory` accesses. Sub-word stores use read-modify-write. Loaded data is sign- or zero-extended and held in an internal memory-data register until the next load completes.

## Interface
- `ADDR_WIDTH`, 32: width of the request address and `mem_address`. Data width is fixed at 32.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request strobe, accepted only while `ready`=1.
- `op` in 3: operation code. LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- `addr` in ADDR_WIDTH: byte address of the request.
- `store_data` in 32: store operand. SB uses bits [7:0]; SH uses bits [15:0].
- `ready` out 1: 1 in IDLE only.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 marks a rejected misaligned request.
- `load_data` out 32: extended load result; held between loads.
- `mem_address` out ADDR_WIDTH: word-aligned address to `DataMemory`; bits [1:0] are always 0.
- `mem_write_data` out 32: to `DataMemory.writeData`.
- `mem_read` out 1: to `DataMemory.MemRead`.
- `mem_write` out 1: to `DataMemory.MemWrite`.
- `mem_read_data` in 32: from `DataMemory.readData`; valid in the cycle after `mem_read` is first asserted.

## Operation
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by `addr[1:0]`. Halfword = lanes {1,0} if `addr[1]`=0, lanes {3,2} if `addr[1]`=1.
- States:
  - **IDLE**: on `start`, latch `op`, `addr`, `store_data`. Next state is ERR if the request is misaligned and the trap is enabled; WRITE for SW; READ for all other ops.
  - **READ**: `mem_read`=1, drive `mem_address`. Next: WAIT.
  - **WAIT**: `mem_read`=1; capture `mem_read_data` into the word register. Loads go to DONE and update `load_data`. SH/SB go to WRITE.
  - **WRITE**: `mem_write`=1 for exactly one cycle. `mem_write_data` is `store_data` for SW; for SH/SB it is the captured word with the addressed lanes replaced. Next: DONE.
  - **ERR**: next state DONE with `err`=1. No memory strobe is issued.
  - **DONE**: `done`=1. Next: IDLE.
- LH/LB sign-extend; LHU/LBU zero-extend.
- `load_data` changes only on a successful load. Stores and errors leave it unchanged.
- `start` is ignored while not IDLE. `op`, `addr` and `store_data` are don't-care after acceptance.
- `mem_read` and `mem_write` are never high together.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `err`=0, `load_data`=0, `mem_address`=0, `mem_write_data`=0, `mem_read`=0, `mem_write`=0.
- Latency from the `start` edge to `done` high:
  - SW: 2 cycles.
  - Any load: 3 cycles.
  - SH/SB: 4 cycles.
  - Error: 2 cycles.
- `ready` returns the cycle after `done`, so back-to-back requests are spaced one cycle apart.
- Reset asserted in any state: the next edge returns the unit to IDLE with reset values. A pending write is not issued and `done` is not pulsed.
- `start` during a reset cycle is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LW/SW with `addr[1:0]`≠0, or LH/LHU/SH with `addr[0]`=1, go to ERR.
  - The result is `done`=1 with `err`=1 and no memory access.
- Undefined:
  - No ERR state exists and `err` is tied 0.
  - Word ops ignore `addr[1:0]`; halfword ops ignore `addr[0]`.

## Structure
- Package `lsu_pkg` holds:
  - the `op` encoding constants or enum;
  - the state enum;
  - the helpers `is_load` and `is_subword`.
- One combinational sub-module, `lsu_byte_lane`, takes the word, `addr[1:0]`, `op` and store data. It produces the extended load value and the merged write word.

## Test plan
- Memory[0x2C]=0x8899AABB; LW `addr`=0x2C -> `mem_read` high for 2 cycles; `done` at +3; `load_data`=0x8899AABB, `err`=0.
- Same memory; LB `addr`=0x2F -> `load_data`=0xFFFFFF88. Then LBU 0x2F -> 0x00000088. Then LHU 0x2C -> 0x0000AABB.
- SB `addr`=0x2D, `store_data`=0x11 -> one `mem_write` pulse with `mem_write_data`=0x889911BB at `mem_address`=0x2C; `done` at +4. A following LW 0x2C returns 0x889911BB.
- Macro defined: LW `addr`=0x2D -> `done` and `err`=1 at +2, no `mem_read`/`mem_write` pulse, `load_data` unchanged. Macro undefined: same request returns memory[0x2C] with `err`=0.
- SH `addr`=0x2E, `store_data`=0x1234; deassert `reset_n` during WAIT -> no `mem_write` pulse, memory still 0x8899AABB, `ready`=1 and all outputs at reset values after the edge.
- `start` pulsed again while busy during an SW -> ignored; exactly one `done` pulse; the next request is accepted only after `ready`=1.
